// File: rtl/fifo_pkg.sv
// Shared types and width helpers for the single-clock FIFO and its storage.
package fifo_pkg;

   typedef enum logic {RD_STD, RD_FWFT} rd_mode_e;
   typedef enum logic {ERR_PULSE, ERR_STICKY} err_mode_e;

   // One extra MSB acts as the wrap bit, so full and empty stay distinguishable.
   function automatic int unsigned ptr_w(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic int unsigned cnt_w(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// WIDTH x DEPTH flop storage with one synchronous write port and one asynchronous read port.
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: count, almost-full/empty thresholds, standard or FWFT read, pulse or sticky errors.
module sync_fifo
   import fifo_pkg::*;
#(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned FWFT       = 0,
   parameter int unsigned STICKY_ERR = 0,
   parameter int unsigned AFULL_TH   = DEPTH - 2,
   parameter int unsigned AEMPTY_TH  = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wen,
   input  logic [WIDTH-1:0]       wdata,
   input  logic                   ren,
   output logic [WIDTH-1:0]       rdata,
   output logic                   rvalid,
   output logic                   full,
   output logic                   empty,
   output logic                   almost_full,
   output logic                   almost_empty,
   output logic                   overflow,
   output logic                   underflow,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned PW = ptr_w(DEPTH);
   localparam int unsigned CW = cnt_w(DEPTH);
   localparam int unsigned AW = PW - 1;
   localparam rd_mode_e  RD_MODE  = (FWFT != 0) ? RD_FWFT : RD_STD;
   localparam err_mode_e ERR_MODE = (STICKY_ERR != 0) ? ERR_STICKY : ERR_PULSE;
   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
   localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

   if (WIDTH < 1) begin : g_bad_width
      $error("sync_fifo: WIDTH must be >= 1");
   end
   if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("sync_fifo: DEPTH must be a power of 2 and >= 4");
   end
   if (FWFT > 1 || STICKY_ERR > 1) begin : g_bad_mode
      $error("sync_fifo: FWFT and STICKY_ERR must be 0 or 1");
   end
   if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull
      $error("sync_fifo: AFULL_TH must be in 1..DEPTH");
   end
   if (AEMPTY_TH > DEPTH - 1) begin : g_bad_aempty
      $error("sync_fifo: AEMPTY_TH must be in 0..DEPTH-1");
   end

   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic             rvalid_q, rvalid_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;
   logic             wr_acc, rd_acc;
   logic [WIDTH-1:0] head;

   fifo_mem #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
   ) u_mem (
      .clk  (clk),
      .we   (wr_acc),
      .waddr(wr_ptr_q[AW-1:0]),
      .wdata(wdata),
      .raddr(rd_ptr_q[AW-1:0]),
      .rdata(head)
   );

   // Acceptance uses the registered flags, so a full FIFO never writes through and an empty one never reads through.
   always_comb begin
      wr_acc      = wen && !full;
      rd_acc      = ren && !empty;
      wr_ptr_d    = wr_ptr_q + PW'(wr_acc);
      rd_ptr_d    = rd_ptr_q + PW'(rd_acc);
      count_d     = wr_ptr_d - rd_ptr_d;
      rdata_d     = rd_acc ? head : rdata_q;
      rvalid_d    = rd_acc;
      overflow_d  = (wen && full)  || (ERR_MODE == ERR_STICKY && overflow_q);
      underflow_d = (ren && empty) || (ERR_MODE == ERR_STICKY && underflow_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         rdata_q     <= '0;
         rvalid_q    <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         rdata_q     <= rdata_d;
         rvalid_q    <= rvalid_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   always_comb begin
      count        = count_q;
      full         = (count_q == DEPTH_C);
      empty        = (count_q == '0);
      almost_full  = (count_q >= AFULL_C);
      almost_empty = (count_q <= AEMPTY_C);
      overflow     = overflow_q;
      underflow    = underflow_q;
      rdata        = (RD_MODE == RD_FWFT) ? head : rdata_q;
      rvalid       = (RD_MODE == RD_FWFT) ? !empty : rvalid_q;
   end

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench: standard, FWFT and sticky-error FIFOs driven with identical stimulus.
module tb_sync_fifo;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wen = 1'b0;
   logic       ren = 1'b0;
   logic [7:0] wdata = '0;

   logic [7:0] s_rdata, f_rdata, k_rdata;
   logic       s_rvalid, f_rvalid, k_rvalid;
   logic       s_full, f_full, k_full;
   logic       s_empty, f_empty, k_empty;
   logic       s_afull, f_afull, k_afull;
   logic       s_aempty, f_aempty, k_aempty;
   logic       s_ovf, f_ovf, k_ovf;
   logic       s_unf, f_unf, k_unf;
   logic [3:0] s_count, f_count, k_count;

   int unsigned checks = 0;
   int unsigned failures = 0;

   logic [7:0] sb[$];
   int unsigned m_cnt = 0;
   logic [7:0]  m_last = '0;
   logic        m_k_ovf = 1'b0;
   logic        m_k_unf = 1'b0;

   always #5 clk = ~clk;

   sync_fifo #(.WIDTH(8), .DEPTH(8), .FWFT(0), .STICKY_ERR(0), .AFULL_TH(6), .AEMPTY_TH(2)) u_std (
      .clk(clk), .rst(rst), .wen(wen), .wdata(wdata), .ren(ren),
      .rdata(s_rdata), .rvalid(s_rvalid), .full(s_full), .empty(s_empty),
      .almost_full(s_afull), .almost_empty(s_aempty),
      .overflow(s_ovf), .underflow(s_unf), .count(s_count));

   sync_fifo #(.WIDTH(8), .DEPTH(8), .FWFT(1), .STICKY_ERR(0), .AFULL_TH(6), .AEMPTY_TH(2)) u_fwft (
      .clk(clk), .rst(rst), .wen(wen), .wdata(wdata), .ren(ren),
      .rdata(f_rdata), .rvalid(f_rvalid), .full(f_full), .empty(f_empty),
      .almost_full(f_afull), .almost_empty(f_aempty),
      .overflow(f_ovf), .underflow(f_unf), .count(f_count));

   sync_fifo #(.WIDTH(8), .DEPTH(8), .FWFT(0), .STICKY_ERR(1), .AFULL_TH(6), .AEMPTY_TH(2)) u_stk (
      .clk(clk), .rst(rst), .wen(wen), .wdata(wdata), .ren(ren),
      .rdata(k_rdata), .rvalid(k_rvalid), .full(k_full), .empty(k_empty),
      .almost_full(k_afull), .almost_empty(k_aempty),
      .overflow(k_ovf), .underflow(k_unf), .count(k_count));

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Flag and output checks shared by all three instances after every edge.
   task automatic check_state(input logic exp_rv, input logic exp_ovf, input logic exp_unf);
      logic [31:0] c;
      c = m_cnt;
      check_eq("s_count", 32'(s_count), c);
      check_eq("s_empty", 32'(s_empty), 32'(m_cnt == 0));
      check_eq("s_full", 32'(s_full), 32'(m_cnt == 8));
      check_eq("s_afull", 32'(s_afull), 32'(m_cnt >= 6));
      check_eq("s_aempty", 32'(s_aempty), 32'(m_cnt <= 2));
      check_eq("s_ovf", 32'(s_ovf), 32'(exp_ovf));
      check_eq("s_unf", 32'(s_unf), 32'(exp_unf));
      check_eq("s_rvalid", 32'(s_rvalid), 32'(exp_rv));
      check_eq("s_rdata", 32'(s_rdata), 32'(m_last));
      check_eq("f_count", 32'(f_count), c);
      check_eq("f_rvalid", 32'(f_rvalid), 32'(m_cnt != 0));
      if (m_cnt != 0) check_eq("f_rdata", 32'(f_rdata), 32'(sb[0]));
      check_eq("f_ovf", 32'(f_ovf), 32'(exp_ovf));
      check_eq("k_count", 32'(k_count), c);
      check_eq("k_ovf", 32'(k_ovf), 32'(m_k_ovf));
      check_eq("k_unf", 32'(k_unf), 32'(m_k_unf));
   endtask

   task automatic cycle(input logic w, input logic [7:0] d, input logic r);
      logic wr_ok, rd_ok, e_ovf, e_unf;
      wen   = w;
      wdata = d;
      ren   = r;
      wr_ok = w && (m_cnt < 8);
      rd_ok = r && (m_cnt > 0);
      e_ovf = w && (m_cnt == 8);
      e_unf = r && (m_cnt == 0);
      if (rd_ok) begin
         m_last = sb.pop_front();
         m_cnt--;
      end
      if (wr_ok) begin
         sb.push_back(d);
         m_cnt++;
      end
      m_k_ovf = m_k_ovf | e_ovf;
      m_k_unf = m_k_unf | e_unf;
      @(posedge clk);
      #1;
      wen = 1'b0;
      ren = 1'b0;
      check_state(rd_ok, e_ovf, e_unf);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      sb.delete();
      m_cnt   = 0;
      m_last  = '0;
      m_k_ovf = 1'b0;
      m_k_unf = 1'b0;
      check_state(1'b0, 1'b0, 1'b0);
      check_eq("rst_k_rvalid", 32'(k_rvalid), 32'd0);
   endtask

   initial begin
      @(posedge clk);
      do_reset();

      // Fill, then one write too many
      for (int i = 1; i <= 8; i++) cycle(1'b1, 8'(i), 1'b0);
      cycle(1'b1, 8'h09, 1'b0);
      cycle(1'b0, 8'h00, 1'b0);

      // Drain, then one read too many
      for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1);
      cycle(1'b0, 8'h00, 1'b1);
      check_eq("drain_hold", 32'(s_rdata), 32'h08);
      cycle(1'b0, 8'h00, 1'b0);

      // Pointer wrap
      for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0);
      for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 6; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0);
      for (int i = 0; i < 6; i++) cycle(1'b0, 8'h00, 1'b1);
      check_eq("wrap_count", 32'(s_count), 32'd0);

      // Simultaneous write and read at mid, full and empty
      for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0);
      cycle(1'b1, 8'h63, 1'b1);
      check_eq("both_mid", 32'(s_count), 32'd3);
      for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h70 + i), 1'b0);
      cycle(1'b1, 8'h7F, 1'b1);
      check_eq("both_full", 32'(s_count), 32'd7);
      for (int i = 0; i < 7; i++) cycle(1'b0, 8'h00, 1'b1);
      cycle(1'b1, 8'h88, 1'b1);
      check_eq("both_empty", 32'(s_count), 32'd1);
      cycle(1'b0, 8'h00, 1'b1);

      // First-word-fall-through visibility
      cycle(1'b1, 8'hA5, 1'b0);
      check_eq("fwft_rdata", 32'(f_rdata), 32'hA5);
      check_eq("fwft_rvalid", 32'(f_rvalid), 32'd1);
      cycle(1'b0, 8'h00, 1'b1);
      check_eq("fwft_empty", 32'(f_empty), 32'd1);

      // Sticky error retention and its clearing by reset
      for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00, 1'b0);
      check_eq("sticky_hold", 32'(k_ovf), 32'd1);
      for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'hB0 + i), 1'b0);
      do_reset();
      check_eq("rst_k_count", 32'(k_count), 32'd0);
      check_eq("rst_k_empty", 32'(k_empty), 32'd1);
      check_eq("rst_k_ovf", 32'(k_ovf), 32'd0);

      // Random traffic against the scoreboard
      for (int i = 0; i < 300; i++) begin
         cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
